ibex_data_responder: RTL



---
 rtl/ibex_resp_pkg.sv | 18 +
 rtl/ibex_resp_pipe.sv | 40 ++++
 rtl/ibex_data_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ibex_resp_pkg.sv
// Shared types and limits for the ibex data-side memory responder.
package ibex_resp_pkg;

   localparam int MAX_WAIT_STATES  = 7;
   localparam int MAX_READ_LATENCY = 4;
   localparam int CNT_W            = $clog2(MAX_WAIT_STATES + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } resp_state_e;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

endpackage

// File: rtl/ibex_resp_pipe.sv
// Fixed-depth response shift register: LAT cycles from in_vld to out_vld, no stall.
// Synchronous clear drops everything in flight.
module ibex_resp_pipe
   import ibex_resp_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic  clock,
   input  logic  reset,
   input  logic  in_vld,
   input  resp_t in_dat,
   output logic  out_vld,
   output resp_t out_dat
);

   logic  [LAT-1:0] vld_q, vld_d;
   resp_t [LAT-1:0] dat_q, dat_d;

   // Payload is zeroed on empty slots so the output needs no extra masking downstream.
   always_comb begin
      vld_d    = vld_q << 1;
      dat_d    = dat_q << $bits(resp_t);
      vld_d[0] = in_vld;
      dat_d[0] = in_vld ? in_dat : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign out_vld = vld_q[LAT-1];
   assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/ibex_data_responder.sv
// Ibex-style data memory slave: WAIT_STATES before gnt, byte-lane writes, in-order responses READ_LATENCY after grant, no back-pressure.
// Define IBEX_DATA_RESP_ERR_EN to answer out-of-range accesses with err instead of wrapping the index.
module ibex_data_responder
   import ibex_resp_pkg::*;
#(
   parameter int unsigned MEM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned WAIT_STATES  = 0,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_req_i,
   output logic        io_gnt_o,
   input  logic        io_we_i,
   input  logic [3:0]  io_be_i,
   input  logic [31:0] io_addr_i,
   input  logic [31:0] io_wdata_i,
   output logic        io_rvalid_o,
   output logic [31:0] io_rdata_o,
   output logic        io_err_o
);

   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   resp_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gnt_raw;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_raw = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (io_req_i) begin
               if (WAIT_STATES == 0) begin
                  gnt_raw = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            // Abandoned request: forget the partial wait entirely.
            if (!io_req_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               gnt_raw = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign io_gnt_o = gnt_raw & ~reset;

   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic          in_range;
   logic [31:0]   rd_word, lane_mask, wr_word;
   logic          wr_en;
   resp_t         resp_in, resp_out;
   logic          resp_vld;

   logic [31:0] mem_q [MEM_WORDS];

   always_comb begin
      offset = io_addr_i - BASE_ADDR;
      idx    = AW'(offset >> 2);
`ifdef IBEX_DATA_RESP_ERR_EN
      in_range = (offset >> (AW + 2)) == 32'd0;
`else
      in_range = 1'b1;
`endif
      rd_word   = mem_q[idx];
      lane_mask = {{8{io_be_i[3]}}, {8{io_be_i[2]}}, {8{io_be_i[1]}}, {8{io_be_i[0]}}};
      wr_word   = (rd_word & ~lane_mask) | (io_wdata_i & lane_mask);
      wr_en     = io_gnt_o & io_we_i & in_range;
      resp_in.rdata = (!io_we_i && in_range) ? rd_word : 32'd0;
      resp_in.err   = ~in_range;
   end

   // Memory is deliberately not reset; contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[idx] <= wr_word;
      end
   end

   ibex_resp_pipe #(
      .LAT (READ_LATENCY)
   ) u_pipe (
      .clock   (clock),
      .reset   (reset),
      .in_vld  (io_gnt_o),
      .in_dat  (resp_in),
      .out_vld (resp_vld),
      .out_dat (resp_out)
   );

   assign io_rvalid_o = resp_vld;
   assign io_rdata_o  = resp_vld ? resp_out.rdata : 32'd0;
   assign io_err_o    = resp_vld & resp_out.err;

endmodule
